// File: rtl/rv_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// the canonical nop word and the default reset PC.
package rv_pkg;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    // addi x0, x0, 0 -- what decode sees before the first fetch lands.
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // A target is unusable when it is not on a 4-byte boundary.  Bit 0 is
    // never examined: jalr clears it, and branch/jal targets are even by
    // construction of the immediate.
    function automatic logic target_misaligned(input logic [1:0] low_bits);
        return low_bits[1];
    endfunction

endpackage

// File: rtl/next_pc_sel.sv
// Next-PC selection: priority mux over jalr / branch-jal / sequential and
// the misalignment check on the selected target.  Purely combinational.
module next_pc_sel
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] pc_plus4,
    input  logic            pc_src,
    input  logic            jalr,
    input  logic [XLEN-1:0] pc_target,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] jalr_target;

    // jalr targets drop bit 0 before use.
    assign jalr_target = {alu_result[XLEN-1:1], 1'b0};

    // Jalr outranks PCSrc; sequential flow is the fallback.
    always_comb begin
        next_pc = pc_plus4;
        if (jalr) begin
            next_pc = jalr_target;
        end else if (pc_src) begin
            next_pc = pc_target;
        end
    end

    assign misaligned = target_misaligned(next_pc[1:0]);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage.  Owns the PC, issues one instruction-memory read
// at a time, holds the returned word for decode until the core retires it,
// then steps or redirects the PC.  A misaligned target traps into HALT,
// which only reset leaves.
//
// imem handshake: imem_req is a valid signal.  Once raised it stays high,
// with imem_addr unchanged, until a cycle in which imem_ready is also high;
// that cycle transfers imem_rdata and imem_req drops on the next edge.
// imem_ready while imem_req is low carries no data and is ignored.
module fetch_unit
    import rv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            PCSrc,
    input  logic            Jalr,
    input  logic [XLEN-1:0] PCTarget,
    input  logic [XLEN-1:0] ALUResult,
    input  logic            advance,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ready,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     Instr,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4,
    output logic            instr_valid,
    output logic            fetch_err,
    output logic [1:0]      fsm_state
);

    fetch_state_t    state;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            req_q;
    logic            valid_q;
    logic            err_q;

    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] next_pc;
    logic            misaligned;

    // Sequential successor, wrapping modulo 2^XLEN.
    assign pc_plus4 = pc_q + XLEN'(4);

    next_pc_sel #(
        .XLEN(XLEN)
    ) u_next_pc_sel (
        .pc_plus4   (pc_plus4),
        .pc_src     (PCSrc),
        .jalr       (Jalr),
        .pc_target  (PCTarget),
        .alu_result (ALUResult),
        .next_pc    (next_pc),
        .misaligned (misaligned)
    );

    // Fetch sequencer: state, PC, held instruction and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                // One quiet cycle after reset; stray ready responses die here.
                S_IDLE: begin
                    state <= S_FETCH;
                    req_q <= 1'b1;
                end
                // Request outstanding at pc_q until memory answers.
                S_FETCH: begin
                    if (imem_ready) begin
                        instr_q <= imem_rdata;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= S_HOLD;
                    end
                end
                // Instruction presented to decode; redirect controls are
                // only consulted on the retiring cycle.
                S_HOLD: begin
                    if (advance) begin
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            err_q <= 1'b1;
                            state <= S_HALT;
                        end else begin
                            pc_q  <= next_pc;
                            req_q <= 1'b1;
                            state <= S_FETCH;
                        end
                    end
                end
                // Trapped: nothing issues, error stays up until reset.
                S_HALT: begin
                    req_q   <= 1'b0;
                    valid_q <= 1'b0;
                    err_q   <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                    req_q <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = pc_q;
    assign Instr       = instr_q;
    assign PC          = pc_q;
    assign PCPlus4     = pc_plus4;
    assign instr_valid = valid_q;
    assign fetch_err   = err_q;
    assign fsm_state   = state;

    // An unanswered request keeps both req and address steady.
    property p_req_hold;
        @(posedge clk) disable iff (reset)
            (imem_req && !imem_ready) |=> (imem_req && $stable(imem_addr));
    endproperty
    a_req_hold: assert property (p_req_hold);

    // A held instruction never overlaps a new request.
    property p_valid_no_req;
        @(posedge clk) disable iff (reset)
            instr_valid |-> !imem_req;
    endproperty
    a_valid_no_req: assert property (p_valid_no_req);

    // The trap flag is sticky.
    property p_err_sticky;
        @(posedge clk) disable iff (reset)
            fetch_err |=> fetch_err;
    endproperty
    a_err_sticky: assert property (p_err_sticky);

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a randomized run checked
// against a transaction-level model of the fetch stage.
module tb_fetch_unit;
    import rv_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrc, Jalr, advance, imem_ready;
    logic [31:0] PCTarget, ALUResult, imem_rdata;
    logic        imem_req, instr_valid, fetch_err;
    logic [31:0] imem_addr, Instr, PC, PCPlus4;
    logic [1:0]  fsm_state;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .reset       (reset),
        .PCSrc       (PCSrc),
        .Jalr        (Jalr),
        .PCTarget    (PCTarget),
        .ALUResult   (ALUResult),
        .advance     (advance),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .Instr       (Instr),
        .PC          (PC),
        .PCPlus4     (PCPlus4),
        .instr_valid (instr_valid),
        .fetch_err   (fetch_err),
        .fsm_state   (fsm_state)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        PCSrc = 0; Jalr = 0; advance = 0; imem_ready = 0;
        PCTarget = '0; ALUResult = '0; imem_rdata = '0;
    endtask

    // Leaves the DUT in its post-reset cycle (IDLE) with reset low.
    task automatic do_reset();
        clear_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Answer the outstanding (or upcoming) request and stop once the
    // instruction is held; bounded so a dead DUT cannot hang the run.
    task automatic wait_hold(input logic [31:0] data);
        bit found = 0;
        imem_ready = 1;
        imem_rdata = data;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (instr_valid === 1'b1) begin
                found = 1;
                break;
            end
        end
        imem_ready = 0;
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("FAIL wait_hold_timeout: instr_valid=%b after 20 cycles, required 1", instr_valid);
        end
    endtask

    // Retire the held instruction with the given redirect controls.
    task automatic step_adv(input logic s, input logic j,
                            input logic [31:0] tgt, input logic [31:0] alu);
        advance = 1; PCSrc = s; Jalr = j; PCTarget = tgt; ALUResult = alu;
        tick();
        advance = 0; PCSrc = 0; Jalr = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        clear_inputs();
        reset = 1;
        imem_ready = 1;
        imem_rdata = 32'hDEAD_BEEF;
        tick();
        tick();
        n_checks++; if (PC !== RST_PC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", PC, RST_PC); end
        n_checks++; if (Instr !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr: got %h want 00000013", Instr); end
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", imem_req); end
        n_checks++; if (fetch_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", fetch_err); end
        n_checks++; if (fsm_state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
        reset = 0;
        // IDLE cycle: ready is high but no request is out.
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL idle_req: got %b want 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin n_fail++; $display("FAIL idle_then_fetch: req=%b addr=%h want 1/%h", imem_req, imem_addr, RST_PC); end
        n_checks++; if (Instr !== 32'h0000_0013 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL idle_ready_ignored: instr=%h valid=%b want 00000013/0", Instr, instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || Instr !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL first_latch: valid=%b instr=%h want 1/deadbeef", instr_valid, Instr); end
        clear_inputs();
    endtask

    task automatic test_basic();
        do_reset();
        imem_ready = 1;
        imem_rdata = 32'h0050_0093;
        advance = 1;
        n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL basic_c1_req: got %b want 0", imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL basic_c2_req: req=%b addr=%h want 1/0", imem_req, imem_addr); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || Instr !== 32'h0050_0093 || PC !== 32'h0 || PCPlus4 !== 32'h4 || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL basic_c3_hold: valid=%b instr=%h pc=%h pc4=%h req=%b want 1/00500093/0/4/0", instr_valid, Instr, PC, PCPlus4, imem_req); end
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_c4_next: req=%b addr=%h valid=%b want 1/4/0", imem_req, imem_addr, instr_valid); end
        tick();
        n_checks++; if (instr_valid !== 1'b1 || PC !== 32'h4) begin n_fail++; $display("FAIL basic_c5_hold: valid=%b pc=%h want 1/4", instr_valid, PC); end
        clear_inputs();
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || instr_valid !== 1'b0)
                begin n_fail++; $display("FAIL stall_%0d: req=%b addr=%h valid=%b want 1/%h/0", i, imem_req, imem_addr, instr_valid, RST_PC); end
            tick();
        end
        imem_ready = 1;
        imem_rdata = 32'h1234_5013;
        tick();
        imem_ready = 0;
        n_checks++; if (instr_valid !== 1'b1 || Instr !== 32'h1234_5013) begin n_fail++; $display("FAIL stall_release: valid=%b instr=%h want 1/12345013", instr_valid, Instr); end
    endtask

    task automatic test_redirect();
        do_reset();
        wait_hold(32'h0000_0013);
        for (int i = 0; i < 4; i++) begin
            step_adv(0, 0, 32'h0, 32'h0);
            wait_hold(32'h0000_0013);
        end
        n_checks++; if (PC !== 32'h10) begin n_fail++; $display("FAIL redir_setup_pc: got %h want 00000010", PC); end
        step_adv(1, 0, 32'h40, 32'h0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_pcsrc: req=%b addr=%h want 1/40", imem_req, imem_addr); end
        wait_hold(32'h0000_0013);
        step_adv(1, 1, 32'h40, 32'h81);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h80) begin n_fail++; $display("FAIL redir_jalr_prio: req=%b addr=%h want 1/80", imem_req, imem_addr); end
    endtask

    // Expects to enter with a fetch outstanding at 0x80.
    task automatic test_hold_stable();
        wait_hold(32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            PCSrc = i[0];
            Jalr = i[1];
            PCTarget = $urandom;
            ALUResult = $urandom;
            tick();
            n_checks++; if (Instr !== 32'h1234_5678 || PC !== 32'h80 || imem_req !== 1'b0 || instr_valid !== 1'b1)
                begin n_fail++; $display("FAIL hold_stable_%0d: instr=%h pc=%h req=%b valid=%b want 12345678/80/0/1", i, Instr, PC, imem_req, instr_valid); end
        end
        clear_inputs();
    endtask

    // Expects to enter holding PC=0x80.
    task automatic test_misalign();
        step_adv(1, 0, 32'h42, 32'h0);
        n_checks++; if (fetch_err !== 1'b1 || fsm_state !== S_HALT) begin n_fail++; $display("FAIL misalign_trap: err=%b state=%0d want 1/%0d", fetch_err, fsm_state, S_HALT); end
        n_checks++; if (PC !== 32'h80 || instr_valid !== 1'b0 || imem_req !== 1'b0) begin n_fail++; $display("FAIL misalign_pc: pc=%h valid=%b req=%b want 80/0/0", PC, instr_valid, imem_req); end
        imem_ready = 1;
        advance = 1;
        for (int i = 0; i < 4; i++) begin
            tick();
            n_checks++; if (imem_req !== 1'b0 || fetch_err !== 1'b1) begin n_fail++; $display("FAIL halt_quiet_%0d: req=%b err=%b want 0/1", i, imem_req, fetch_err); end
        end
        clear_inputs();
    endtask

    task automatic test_reset_mid_fetch();
        do_reset();
        wait_hold(32'h0000_0013);
        step_adv(0, 0, 32'h0, 32'h0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin n_fail++; $display("FAIL rmf_setup: req=%b addr=%h want 1/4", imem_req, imem_addr); end
        reset = 1;
        imem_ready = 1;
        imem_rdata = 32'hCAFE_F00D;
        tick();
        n_checks++; if (PC !== RST_PC || instr_valid !== 1'b0 || Instr !== 32'h0000_0013 || imem_req !== 1'b0)
            begin n_fail++; $display("FAIL rmf_after: pc=%h valid=%b instr=%h req=%b want %h/0/00000013/0", PC, instr_valid, Instr, imem_req, RST_PC); end
        reset = 0;
        tick();
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== RST_PC || Instr !== 32'h0000_0013)
            begin n_fail++; $display("FAIL rmf_refetch: req=%b addr=%h instr=%h want 1/%h/00000013", imem_req, imem_addr, Instr, RST_PC); end
        clear_inputs();
    endtask

    task automatic test_wrap();
        do_reset();
        wait_hold(32'h0000_0013);
        step_adv(0, 1, 32'h0, 32'hFFFF_FFFD);
        n_checks++; if (imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: addr=%h want fffffffc", imem_addr); end
        wait_hold(32'h0000_0013);
        n_checks++; if (PCPlus4 !== 32'h0) begin n_fail++; $display("FAIL wrap_pcplus4: got %h want 00000000", PCPlus4); end
        step_adv(0, 0, 32'h0, 32'h0);
        n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0 || fetch_err !== 1'b0)
            begin n_fail++; $display("FAIL wrap_seq: req=%b addr=%h err=%b want 1/0/0", imem_req, imem_addr, fetch_err); end
    endtask

    // Transaction-level model: each instruction is one fetch at the model PC
    // followed by a retire that picks the next PC from the redirect rules.
    task automatic test_random();
        logic [31:0] mpc, data, tgt, alu, nxt;
        logic        s, j;
        int          w, h;
        do_reset();
        tick();
        mpc = RST_PC;
        for (int n = 0; n < 60; n++) begin
            w = $urandom_range(0, 3);
            for (int i = 0; i < w; i++) begin
                advance = $urandom_range(0, 1);
                PCSrc = $urandom_range(0, 1);
                PCTarget = $urandom;
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_wait n=%0d: req=%b addr=%h valid=%b want 1/%h/0", n, imem_req, imem_addr, instr_valid, mpc); end
                tick();
            end
            advance = 0; PCSrc = 0;
            data = $urandom;
            imem_ready = 1;
            imem_rdata = data;
            tick();
            imem_ready = 0;
            n_checks++; if (instr_valid !== 1'b1 || Instr !== data || PC !== mpc || PCPlus4 !== mpc + 32'd4)
                begin n_fail++; $display("FAIL rnd_hold n=%0d: valid=%b instr=%h pc=%h pc4=%h want 1/%h/%h/%h", n, instr_valid, Instr, PC, PCPlus4, data, mpc, mpc + 32'd4); end
            h = $urandom_range(0, 2);
            for (int i = 0; i < h; i++) begin
                PCSrc = $urandom_range(0, 1);
                Jalr = $urandom_range(0, 1);
                tick();
                n_checks++; if (instr_valid !== 1'b1 || Instr !== data || PC !== mpc || imem_req !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_stay n=%0d: valid=%b instr=%h pc=%h req=%b", n, instr_valid, Instr, PC, imem_req); end
            end
            s = ($urandom_range(0, 2) == 0);
            j = ($urandom_range(0, 3) == 0);
            tgt = $urandom & 32'hFFFF_FFFC;
            alu = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 9) == 0) tgt = tgt | 32'h2;
            if ($urandom_range(0, 9) == 0) alu = alu | 32'h3;
            else if ($urandom_range(0, 3) == 0) alu = alu | 32'h1;
            if (j) nxt = alu & 32'hFFFF_FFFE;
            else if (s) nxt = tgt;
            else nxt = mpc + 32'd4;
            step_adv(s, j, tgt, alu);
            if (nxt[1]) begin
                n_checks++; if (fetch_err !== 1'b1 || PC !== mpc || imem_req !== 1'b0 || instr_valid !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_trap n=%0d: err=%b pc=%h req=%b valid=%b want 1/%h/0/0", n, fetch_err, PC, imem_req, instr_valid, mpc); end
                do_reset();
                tick();
                mpc = RST_PC;
            end else begin
                mpc = nxt;
                n_checks++; if (imem_req !== 1'b1 || imem_addr !== mpc || instr_valid !== 1'b0 || fetch_err !== 1'b0)
                    begin n_fail++; $display("FAIL rnd_next n=%0d: req=%b addr=%h valid=%b err=%b want 1/%h/0/0", n, imem_req, imem_addr, instr_valid, fetch_err, mpc); end
            end
        end
        clear_inputs();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        reset = 1;
        clear_inputs();
        test_reset();
        test_basic();
        test_stall();
        test_redirect();
        test_hold_stable();
        test_misalign();
        test_reset_mid_fetch();
        test_wrap();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1);
    end

endmodule
